// File: rtl/queue_reader.sv
// Consumer side of the 8-deep byte queue: dequeue pulse -> capture next cycle -> present to sink over valid/ready.
// valid_out rises 2 cycles after dequeue_out; a held byte waits indefinitely for ready_in; flush drains and discards.
module queue_reader #(
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_10khz,
    input  logic             reset_n,
    input  logic             enable_in,
    input  logic             flush_in,
    input  logic [3:0]       len_in,
    input  logic [7:0]       q_data_in,
    output logic             dequeue_out,
    output logic [7:0]       data_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             busy_out,
    output logic [CNT_W-1:0] rd_count_out
);

    typedef enum logic [2:0] {
        IDLE, REQ, CAPT, PRESENT, DRAIN_REQ, DRAIN_CAPT, GAP
    } state_t;

    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
    localparam state_t     AFTER_BYTE = (GAP_CYCLES > 0) ? GAP : IDLE;

    state_t             state_q, state_d;
    logic               deq_q, deq_d;
    logic [7:0]         data_q, data_d;
    logic               vld_q, vld_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         gap_q, gap_d;
    logic               dispatch;

    always_comb begin
        state_d  = state_q;
        deq_d    = 1'b0;
        data_d   = data_q;
        vld_d    = vld_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        dispatch = 1'b0;

        case (state_q)
            IDLE:       dispatch = 1'b1;
            REQ:        state_d  = CAPT;
            CAPT: begin
                data_d  = q_data_in;
                vld_d   = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (vld_q && ready_in) begin
                    vld_d   = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    gap_d   = 8'd0;
                    state_d = AFTER_BYTE;
                end
            end
            DRAIN_REQ:  state_d = DRAIN_CAPT;
            DRAIN_CAPT: begin
                gap_d   = 8'd0;
                state_d = AFTER_BYTE;
            end
            // The last gap cycle makes the IDLE decision itself, so exactly
            // GAP_CYCLES cycles separate a handshake from the next dequeue slot.
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    dispatch = 1'b1;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default:    state_d = IDLE;
        endcase

        if (dispatch) begin
            if (flush_in && (len_in != 4'd0)) begin
                state_d = DRAIN_REQ;
                deq_d   = 1'b1;
            end else if (enable_in && (len_in != 4'd0)) begin
                state_d = REQ;
                deq_d   = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_10khz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            deq_q   <= 1'b0;
            data_q  <= 8'd0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            deq_q   <= deq_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

    assign dequeue_out  = deq_q;
    assign data_out     = data_q;
    assign valid_out    = vld_q;
    assign busy_out     = busy_q;
    assign rd_count_out = cnt_q;

endmodule

// File: tb/tb_queue_reader.sv
// Bench for queue_reader: FIFO queue model plus scoreboard of expected delivered bytes.
module tb_queue_reader;

    logic        clk_10khz = 1'b0;
    logic        reset_n;
    always #5 clk_10khz = ~clk_10khz;

    // dut0: GAP_CYCLES=0, CNT_W=16, fed by a queue model
    logic        en0, fl0, rdy0, deq0, vld0, busy0;
    logic [3:0]  len0;
    logic [7:0]  qdat0, dout0;
    logic [15:0] cnt0;

    // dut1: GAP_CYCLES=4, CNT_W=4, fed by an endless counting source
    logic        en1, fl1, rdy1, deq1, vld1, busy1;
    logic [3:0]  len1;
    logic [7:0]  qdat1, dout1, src1;
    logic [3:0]  cnt1;

    queue_reader #(.GAP_CYCLES(0), .CNT_W(16)) dut0 (
        .clk_10khz(clk_10khz), .reset_n(reset_n), .enable_in(en0), .flush_in(fl0),
        .len_in(len0), .q_data_in(qdat0), .dequeue_out(deq0), .data_out(dout0),
        .valid_out(vld0), .ready_in(rdy0), .busy_out(busy0), .rd_count_out(cnt0));

    queue_reader #(.GAP_CYCLES(4), .CNT_W(4)) dut1 (
        .clk_10khz(clk_10khz), .reset_n(reset_n), .enable_in(en1), .flush_in(fl1),
        .len_in(len1), .q_data_in(qdat1), .dequeue_out(deq1), .data_out(dout1),
        .valid_out(vld1), .ready_in(rdy1), .busy_out(busy1), .rd_count_out(cnt1));

    // Queue model: head byte appears on qdat0 the cycle after a dequeue pulse.
    logic [7:0] qm[$];
    logic       push_vld, q_clr;
    logic [7:0] push_dat;

    always @(posedge clk_10khz) begin
        if (q_clr) begin
            qm.delete();
        end else begin
            if (deq0 && qm.size() > 0) qdat0 <= qm.pop_front();
            if (push_vld && qm.size() < 8) qm.push_back(push_dat);
        end
        len0 <= 4'(qm.size());
    end

    always @(posedge clk_10khz or negedge reset_n) begin
        if (!reset_n) begin
            qdat1 <= 8'd0;
            src1  <= 8'd0;
        end else if (deq1) begin
            qdat1 <= src1;
            src1  <= src1 + 8'd1;
        end
    end

    int         checks, errors, cyc;
    logic [7:0] exp_q[$];
    int         exp_cnt, deq_cnt, hs_cnt, last_deq0;
    logic       prev_deq;
    int         deq1_cnt, hs1_cnt, last_deq1;

    typedef struct {
        logic en;
        logic fl;
        int   n;
        int   exp_deq;
        int   exp_dlv;
        int   exp_len;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: inputs set before the call are what the DUTs see at the posedge.
    task automatic tick();
        logic       hs, pv, hs1;
        logic [7:0] pd, pd1, ed;
        hs  = vld0 && rdy0;
        pv  = vld0;
        pd  = dout0;
        hs1 = vld1 && rdy1;
        pd1 = dout1;
        @(negedge clk_10khz);
        cyc++;
        if (hs) begin
            hs_cnt++;
            exp_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none", pd);
            end else begin
                ed = exp_q.pop_front();
                check("byte_order", {24'd0, pd}, {24'd0, ed});
            end
        end else if (pv) begin
            check("hold_stable", {23'd0, vld0, dout0}, {23'd0, 1'b1, pd});
        end
        if (deq0) begin
            deq_cnt++;
            check("deq_rule", {31'd0, (prev_deq || len0 == 4'd0)}, 32'd0);
            last_deq0 = cyc;
        end
        prev_deq = deq0;
        if (vld0 && !pv) check("latency", cyc - last_deq0, 32'd2);
        check("rd_count", {16'd0, cnt0}, {16'd0, 16'(exp_cnt)});
        if (hs1) begin
            check("gap_data", {24'd0, pd1}, {24'd0, 8'(hs1_cnt)});
            hs1_cnt++;
        end
        if (deq1) begin
            deq1_cnt++;
            if (last_deq1 >= 0) check("gap_spacing", cyc - last_deq1, 32'd7);
            last_deq1 = cyc;
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        q_clr    = 1'b1;
        push_vld = 1'b0;
        en0 = 1'b0; fl0 = 1'b0; rdy0 = 1'b0;
        en1 = 1'b0; fl1 = 1'b0; rdy1 = 1'b0; len1 = 4'd0;
        exp_q.delete();
        exp_cnt  = 0;
        prev_deq = 1'b0;
        repeat (2) @(negedge clk_10khz);
        reset_n = 1'b1;
        q_clr   = 1'b0;
        tick();
        tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        push_vld = 1'b1;
        push_dat = b;
        exp_q.push_back(b);
        tick();
        push_vld = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        last_deq0 = -100; last_deq1 = -1;
        deq_cnt = 0; hs_cnt = 0; deq1_cnt = 0; hs1_cnt = 0;
        push_dat = 8'd0;

        vecs[0] = '{1'b0, 1'b0, 0, 0, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 0, 0, 0, 0};
        vecs[2] = '{1'b0, 1'b0, 3, 0, 0, 3};
        vecs[3] = '{1'b1, 1'b0, 1, 1, 1, 0};
        vecs[4] = '{1'b1, 1'b0, 3, 3, 3, 0};
        vecs[5] = '{1'b0, 1'b1, 5, 5, 0, 0};
        vecs[6] = '{1'b1, 1'b1, 3, 3, 0, 0};
        vecs[7] = '{1'b0, 1'b1, 0, 0, 0, 0};
        vecs[8] = '{1'b1, 1'b0, 8, 8, 8, 0};

        do_reset();
        check("rst_deq",   {31'd0, deq0},  32'd0);
        check("rst_valid", {31'd0, vld0},  32'd0);
        check("rst_data",  {24'd0, dout0}, 32'd0);
        check("rst_busy",  {31'd0, busy0}, 32'd0);
        check("rst_cnt",   {16'd0, cnt0},  32'd0);
        check("rst_cnt1",  {28'd0, cnt1},  32'd0);

        for (int r = 0; r < 9; r++) begin
            do_reset();
            for (int i = 0; i < vecs[r].n; i++) push_byte(8'(r * 16 + i + 1));
            tick();
            deq_cnt = 0;
            hs_cnt  = 0;
            en0  = vecs[r].en;
            fl0  = vecs[r].fl;
            rdy0 = 1'b1;
            repeat (40) tick();
            check($sformatf("row%0d_deq", r), deq_cnt, vecs[r].exp_deq);
            check($sformatf("row%0d_dlv", r), hs_cnt, vecs[r].exp_dlv);
            check($sformatf("row%0d_len", r), {28'd0, len0}, vecs[r].exp_len);
            check($sformatf("row%0d_cnt", r), {16'd0, cnt0}, vecs[r].exp_dlv);
            check($sformatf("row%0d_idle", r), {30'd0, vld0, busy0}, 32'd0);
        end

        // Single byte: pulse, capture, one-cycle valid with ready held high.
        do_reset();
        push_byte(8'h3C);
        tick();
        deq_cnt = 0; hs_cnt = 0;
        en0 = 1'b1; rdy0 = 1'b1;
        for (int k = 0; k < 10 && !deq0; k++) tick();
        check("single_deq", {31'd0, deq0}, 32'd1);
        tick();
        check("single_capt_valid", {31'd0, vld0}, 32'd0);
        tick();
        check("single_present", {23'd0, vld0, dout0}, {23'd0, 1'b1, 8'h3C});
        tick();
        check("single_valid_drop", {31'd0, vld0}, 32'd0);
        check("single_cnt", {16'd0, cnt0}, 32'd1);
        repeat (10) tick();
        check("single_deq_total", deq_cnt, 32'd1);

        // Backpressure: only the first byte is dequeued while the sink stalls.
        do_reset();
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
        tick();
        deq_cnt = 0; hs_cnt = 0;
        en0 = 1'b1; rdy0 = 1'b0;
        for (int k = 0; k < 20 && !vld0; k++) tick();
        check("bp_valid", {31'd0, vld0}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_hold", {23'd0, vld0, dout0}, {23'd0, 1'b1, 8'h11});
        end
        check("bp_one_deq", deq_cnt, 32'd1);
        rdy0 = 1'b1;
        repeat (20) tick();
        check("bp_deq_total", deq_cnt, 32'd3);
        check("bp_dlv", hs_cnt, 32'd3);
        check("bp_cnt", {16'd0, cnt0}, 32'd3);
        check("bp_len", {28'd0, len0}, 32'd0);

        // Asynchronous reset while a byte is held.
        do_reset();
        push_byte(8'hA5);
        tick();
        en0 = 1'b1; rdy0 = 1'b0;
        for (int k = 0; k < 20 && !vld0; k++) tick();
        check("arst_pre", {23'd0, vld0, dout0}, {23'd0, 1'b1, 8'hA5});
        #2 reset_n = 1'b0;
        #1;
        check("arst_deq",   {31'd0, deq0},  32'd0);
        check("arst_valid", {31'd0, vld0},  32'd0);
        check("arst_data",  {24'd0, dout0}, 32'd0);
        check("arst_busy",  {31'd0, busy0}, 32'd0);
        check("arst_cnt",   {16'd0, cnt0},  32'd0);

        // Random traffic against the FIFO scoreboard.
        do_reset();
        deq_cnt = 0; hs_cnt = 0;
        for (int k = 0; k < 800; k++) begin
            rdy0 = ($urandom_range(0, 3) != 0);
            en0  = ($urandom_range(0, 7) != 0);
            if (len0 < 4'd7 && $urandom_range(0, 2) == 0) push_byte(8'($urandom));
            else tick();
        end
        en0 = 1'b1; rdy0 = 1'b1;
        repeat (60) tick();
        check("rand_drained", exp_q.size(), 32'd0);
        check("rand_len", {28'd0, len0}, 32'd0);
        check("rand_deq_eq_dlv", deq_cnt, hs_cnt);

        // Gap spacing and counter wrap on dut1.
        do_reset();
        deq1_cnt = 0; hs1_cnt = 0; last_deq1 = -1;
        len1 = 4'd5; en1 = 1'b1; rdy1 = 1'b1;
        for (int k = 0; k < 400 && deq1_cnt < 17; k++) tick();
        len1 = 4'd0;
        repeat (20) tick();
        check("gap_deq_total", deq1_cnt, 32'd17);
        check("gap_dlv_total", hs1_cnt, 32'd17);
        check("gap_cnt_wrap", {28'd0, cnt1}, 32'd1);
        check("gap_idle", {30'd0, vld1, busy1}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
